// File: rtl/fpaddsub_align_pipe_if.sv
// Handshake and data bundle for the FP add/sub alignment stage.
// Upstream operand pair on in_*, aligned result on out_*.
interface fpaddsub_align_pipe_if #(
  parameter int EW   = 3,
  parameter int MW   = 4,
  parameter int TAGW = 1
);
  logic                in_valid;
  logic                in_ready;
  logic [EW+MW-1:0]    a;
  logic [EW+MW-1:0]    b;
  logic [TAGW-1:0]     in_tag;
  logic                out_valid;
  logic                out_ready;
  logic                max_ab;
  logic [EW-1:0]       cexp;
  logic [EW-1:0]       shift;
  logic [MW-1:0]       mmax;
  logic [MW+2:0]       mmin_aln;
  logic [TAGW-1:0]     out_tag;

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, max_ab, cexp, shift, mmax, mmin_aln, out_tag
  );

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, max_ab, cexp, shift, mmax, mmin_aln, out_tag
  );
endinterface

// File: rtl/fpaddsub_align_pipe.sv
// Two-stage alignment for FP add/sub: S1 compare/select/exponent difference,
// S2 right-shift of the smaller mantissa with guard/round/sticky.
module fpaddsub_align_pipe #(
  parameter int EW   = 3,
  parameter int MW   = 4,
  parameter int TAGW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fpaddsub_align_pipe_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int XW     = MW + 2;

  logic [STAGES:1]  r_vld_pipe;
  logic             w_adv;

  logic             r_s1_max;
  logic [EW-1:0]    r_s1_cexp;
  logic [EW-1:0]    r_s1_shift;
  logic [MW-1:0]    r_s1_mmax;
  logic [MW-1:0]    r_s1_mmin;
  logic [TAGW-1:0]  r_s1_tag;

  logic             r_s2_max;
  logic [EW-1:0]    r_s2_cexp;
  logic [EW-1:0]    r_s2_shift;
  logic [MW-1:0]    r_s2_mmax;
  logic [MW+2:0]    r_s2_aln;
  logic [TAGW-1:0]  r_s2_tag;

  logic             w_b_gt;
  logic [EW+MW-1:0] w_lg;
  logic [EW+MW-1:0] w_sm;
  logic [EW-1:0]    w_diff;

  logic [XW-1:0]    w_x;
  logic [XW-1:0]    w_mask;
  logic [XW-1:0]    w_y;
  logic             w_s;

  // Whole pipe stalls together: bubbles are held, never squeezed out.
  assign w_adv        = bus.out_ready | ~r_vld_pipe[STAGES];
  assign bus.in_ready = w_adv;

  // Exponents sit in the MSBs, so the larger full word also has the larger exponent.
  assign w_b_gt = bus.a < bus.b;
  assign w_lg   = w_b_gt ? bus.b : bus.a;
  assign w_sm   = w_b_gt ? bus.a : bus.b;
  assign w_diff = w_lg[EW+MW-1:MW] - w_sm[EW+MW-1:MW];

  always_comb begin
    w_x    = {r_s1_mmin, 2'b00};
    w_mask = ~({XW{1'b1}} << r_s1_shift);
    w_y    = '0;
    w_s    = 1'b0;
    if (int'(r_s1_shift) < XW) begin
      w_y = w_x >> r_s1_shift;
      w_s = |(w_x & w_mask);
    end else begin
      // Everything shifted out: only the sticky bit survives.
      w_y = '0;
      w_s = |r_s1_mmin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_max   <= 1'b0;
      r_s1_cexp  <= '0;
      r_s1_shift <= '0;
      r_s1_mmax  <= '0;
      r_s1_mmin  <= '0;
      r_s1_tag   <= '0;
      r_s2_max   <= 1'b0;
      r_s2_cexp  <= '0;
      r_s2_shift <= '0;
      r_s2_mmax  <= '0;
      r_s2_aln   <= '0;
      r_s2_tag   <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
      r_s1_max   <= w_b_gt;
      r_s1_cexp  <= w_lg[EW+MW-1:MW];
      r_s1_shift <= w_diff;
      r_s1_mmax  <= w_lg[MW-1:0];
      r_s1_mmin  <= w_sm[MW-1:0];
      r_s1_tag   <= bus.in_tag;
      r_s2_max   <= r_s1_max;
      r_s2_cexp  <= r_s1_cexp;
      r_s2_shift <= r_s1_shift;
      r_s2_mmax  <= r_s1_mmax;
      r_s2_aln   <= {w_y, w_s};
      r_s2_tag   <= r_s1_tag;
    end
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.max_ab    = r_s2_max;
  assign bus.cexp      = r_s2_cexp;
  assign bus.shift     = r_s2_shift;
  assign bus.mmax      = r_s2_mmax;
  assign bus.mmin_aln  = r_s2_aln;
  assign bus.out_tag   = r_s2_tag;
endmodule

// File: tb/tb_fpaddsub_align_pipe.sv
// Scoreboard bench for fpaddsub_align_pipe: directed corner pairs, stall,
// random traffic with random backpressure, and asynchronous reset mid-flight.
module tb_fpaddsub_align_pipe;
  localparam int EW   = 3;
  localparam int MW   = 4;
  localparam int TAGW = 2;
  localparam int RW   = 1 + EW + EW + MW + (MW + 3) + TAGW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpaddsub_align_pipe_if #(.EW(EW), .MW(MW), .TAGW(TAGW)) bus ();

  fpaddsub_align_pipe #(.EW(EW), .MW(MW), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [RW-1:0] res_t;
  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exponent/mantissa split and alignment by integer division.
  function automatic res_t model(input int a, input int b, input int tag);
    int ea, eb, ma, mb, el, ml, es, ms, sh, x, y, s, p;
    logic        mx;
    logic [EW-1:0]   ce, shv;
    logic [MW-1:0]   mm;
    logic [MW+2:0]   al;
    logic [TAGW-1:0] tg;
    ea = a >> MW; ma = a % (1 << MW);
    eb = b >> MW; mb = b % (1 << MW);
    mx = (b > a);
    if (b > a) begin el = eb; ml = mb; es = ea; ms = ma; end
    else       begin el = ea; ml = ma; es = eb; ms = mb; end
    sh = el - es;
    x  = ms * 4;
    if (sh < MW + 2) begin
      p = 1 << sh;
      y = x / p;
      s = (x % p != 0) ? 1 : 0;
    end else begin
      y = 0;
      s = (ms != 0) ? 1 : 0;
    end
    ce = EW'(el); shv = EW'(sh); mm = MW'(ml); al = (MW+3)'(y * 2 + s); tg = TAGW'(tag);
    return {mx, ce, shv, mm, al, tg};
  endfunction

  // Monitor: pops on every output transfer, and checks outputs hold while stalled.
  res_t snap;
  bit   prev_stall = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      res_t act;
      act = {bus.max_ab, bus.cexp, bus.shift, bus.mmax, bus.mmin_aln, bus.out_tag};
      if (prev_stall && bus.out_valid) chk("stall_hold", 32'(act), 32'(snap));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'(act), 32'hFFFF_FFFF);
        else chk("result", 32'(act), 32'(sb.pop_front()));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      snap = act;
    end else prev_stall = 0;
  end

  task automatic send(input int a, input int b, input int tag);
    int n;
    bus.a = (EW+MW)'(a); bus.b = (EW+MW)'(b); bus.in_tag = TAGW'(tag);
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        errors++; checks++;
        break;
      end
    end
    sb.push_back(model(a, b, tag));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string name);
    chk(name, 32'({bus.out_valid, bus.max_ab, bus.cexp, bus.shift, bus.mmax,
                   bus.mmin_aln, bus.out_tag}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    rnd_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("reset_state");
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    // Basic case, exact two-edge latency and spec values.
    send(7'b101_1000, 7'b011_1100, 1);
    chk("lat_edge1", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(bus.out_valid), 32'd1);
    chk("t1_cexp", 32'(bus.cexp), 32'b101);
    chk("t1_shift", 32'(bus.shift), 32'd2);
    chk("t1_mmax", 32'(bus.mmax), 32'b1000);
    chk("t1_aln", 32'(bus.mmin_aln), 32'b0011_000);
    drain();

    // Guard/sticky, saturation, zero mantissa, tie and near-tie.
    send(7'b101_0001, 7'b001_1011, 2);
    send(7'b111_0001, 7'b000_0010, 3);
    send(7'b111_0001, 7'b000_0000, 0);
    send(7'b010_0110, 7'b010_0110, 1);
    send(7'b010_0101, 7'b010_0110, 2);
    send(7'b000_0011, 7'b110_1111, 3);
    drain();

    // Stream 4 tagged pairs, freeze output for 3 cycles once valid.
    fork
      for (int i = 0; i < 4; i++) send($urandom_range(0, 127), $urandom_range(0, 127), i);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 50);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic under random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Async reset with two pairs in flight.
    send(7'b110_1010, 7'b100_0111, 1);
    send(7'b011_0001, 7'b011_1001, 2);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("async_reset");
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_empty", 32'(bus.out_valid), 32'd0);
    send(7'b100_1111, 7'b001_0101, 3);
    send(7'b000_0001, 7'b000_0001, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
